// File: rtl/mult_arbiter_pkg.sv
// Shared constants and helpers for the two-port multiplier arbiter.
package mult_arbiter_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int NUM_PORTS = 2;
   localparam int OP_W      = 32;
   localparam int PROD_W    = 64;

   // Iterations needed for a 2-bit-per-step multiply: ceil(bitlen(v)/2), 0..16.
   function automatic logic [4:0] mul_steps(input logic [OP_W-1:0] v);
      logic [5:0] bl;
      bl = '0;
      for (int i = 0; i < OP_W; i++) begin
         if (v[i]) bl = 6'(i + 1);
      end
      return 5'((bl + 6'd1) >> 1);
   endfunction

   function automatic logic [NUM_PORTS-1:0] port_onehot(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/mult_arbiter_mult32.sv
// Iterative signed 32x32 multiplier: sign-magnitude, two multiplier bits per cycle.
// Unreset by design; mult_begin low for one cycle clears its running flag.
module Multiplier32
   import mult_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              mult_begin,
   input  logic [OP_W-1:0]   op1,
   input  logic [OP_W-1:0]   op2,
   output logic              mult_end,
   output logic [PROD_W-1:0] product
);
   logic              running;
   logic              neg;
   logic [4:0]        cnt;
   logic [PROD_W-1:0] mcand;
   logic [PROD_W-1:0] acc;
   logic [OP_W-1:0]   mplier;
   logic [OP_W-1:0]   mag1;
   logic [OP_W-1:0]   mag2;
   logic [PROD_W-1:0] pp;

   // 0x80000000 negates to itself, which is the correct unsigned magnitude.
   assign mag1 = op1[OP_W-1] ? -op1 : op1;
   assign mag2 = op2[OP_W-1] ? -op2 : op2;
   assign pp   = (mplier[0] ? mcand : '0) + (mplier[1] ? {mcand[PROD_W-2:0], 1'b0} : '0);

   assign mult_end = running && (cnt == 5'd0);
   assign product  = neg ? -acc : acc;

   always_ff @(posedge clk) begin
      if (!mult_begin) begin
         running <= 1'b0;
      end else if (!running) begin
         running <= 1'b1;
         mcand   <= {32'd0, mag1};
         mplier  <= mag2;
         acc     <= '0;
         neg     <= op1[OP_W-1] ^ op2[OP_W-1];
         cnt     <= mul_steps(mag2);
      end else if (cnt != 5'd0) begin
         acc    <= acc + pp;
         mcand  <= {mcand[PROD_W-3:0], 2'b00};
         mplier <= {2'b00, mplier[OP_W-1:2]};
         cnt    <= cnt - 5'd1;
      end else begin
         running <= 1'b0;
      end
   end
endmodule

// File: rtl/mult_arbiter.sv
// Two-port round-robin front end sharing one Multiplier32 through an IDLE/BUSY/RESP FSM.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int RR_INIT = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_PORTS-1:0]      req_valid,
   output logic [NUM_PORTS-1:0]      req_ready,
   input  logic [NUM_PORTS*OP_W-1:0] req_op1,
   input  logic [NUM_PORTS*OP_W-1:0] req_op2,
   output logic [NUM_PORTS-1:0]      resp_valid,
   input  logic [NUM_PORTS-1:0]      resp_ready,
   output logic [PROD_W-1:0]         resp_product,
   input  logic                      flush,
   output logic                      busy
);
   localparam logic PRIO_INIT = RR_INIT[0];

   logic [1:0]        state;
   logic              owner;
   logic              prio;
   logic [OP_W-1:0]   op1_q;
   logic [OP_W-1:0]   op2_q;
   logic [PROD_W-1:0] result;
   logic              mult_begin;
   logic              mult_end;
   logic [PROD_W-1:0] product;
   logic              gnt;
   logic              gnt_port;

   always_comb begin
      gnt_port = prio;
      if (req_valid == 2'b01)      gnt_port = 1'b0;
      else if (req_valid == 2'b10) gnt_port = 1'b1;
   end

   assign gnt          = (state == ST_IDLE) && (|req_valid) && !flush && !rst;
   assign req_ready    = gnt ? port_onehot(gnt_port) : '0;
   assign resp_valid   = (state == ST_RESP) ? port_onehot(owner) : '0;
   assign resp_product = (state == ST_RESP) ? result : '0;
   assign busy         = (state != ST_IDLE);
   // Low in RESP and IDLE, so the multiplier never restarts on held operands.
   assign mult_begin   = (state == ST_BUSY);

   Multiplier32 u_mult (
      .clk        (clk),
      .mult_begin (mult_begin),
      .op1        (op1_q),
      .op2        (op2_q),
      .mult_end   (mult_end),
      .product    (product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         owner  <= 1'b0;
         prio   <= PRIO_INIT;
         op1_q  <= '0;
         op2_q  <= '0;
         result <= '0;
      end else begin
         case (state)
            ST_IDLE: if (gnt) begin
               state <= ST_BUSY;
               owner <= gnt_port;
               op1_q <= gnt_port ? req_op1[2*OP_W-1:OP_W] : req_op1[OP_W-1:0];
               op2_q <= gnt_port ? req_op2[2*OP_W-1:OP_W] : req_op2[OP_W-1:0];
            end
            ST_BUSY: if (flush) begin
               state <= ST_IDLE;
            end else if (mult_end) begin
               result <= product;
               state  <= ST_RESP;
            end
            ST_RESP: if (flush) begin
               state  <= ST_IDLE;
               result <= '0;
            end else if (resp_ready[owner]) begin
               state <= ST_IDLE;
               prio  <= ~owner;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: arbitration, latency, backpressure, flush and reset.
module tb_mult_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_op1;
   logic [63:0] req_op2;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [63:0] resp_product;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_arbiter #(.RR_INIT(0)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op1      (req_op1),
      .req_op2      (req_op2),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_product (resp_product),
      .flush        (flush),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_ops(input int p, input logic [31:0] a, input logic [31:0] b);
      if (p == 0) begin
         req_op1[31:0] = a;
         req_op2[31:0] = b;
      end else begin
         req_op1[63:32] = a;
         req_op2[63:32] = b;
      end
   endtask

   // Called one cycle after the grant; n counts cycles from the grant cycle.
   task automatic wait_resp(input string tag, input int exp_n, input logic [1:0] exp_port,
                            input logic [63:0] exp_p);
      int n;
      n = 1;
      mid();
      while (resp_valid == 2'b00 && n < 40) begin
         tick();
         n++;
         mid();
      end
      check({tag, "_lat"}, 64'(n), 64'(exp_n));
      check({tag, "_port"}, {62'd0, resp_valid}, {62'd0, exp_port});
      check({tag, "_prod"}, resp_product, exp_p);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
      req_op1 = '0; req_op2 = '0;
      set_ops(0, 32'd7, -32'sd3);
      set_ops(1, -32'sd6, 32'd4);
      tick(); tick();
      req_valid = 2'b11;
      mid();
      check("rst_req_ready", {62'd0, req_ready}, 64'd0);
      check("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_product", resp_product, 64'd0);
      tick();
      rst = 1'b0;

      // contention from reset, resp_ready held high beforehand
      mid();
      check("cont_grant0", {62'd0, req_ready}, 64'h1);
      tick();
      req_valid = 2'b10; resp_ready = 2'b11;
      check("cont_busy_noready", {62'd0, req_ready}, 64'd0);
      wait_resp("mul_7x-3", 4, 2'b01, 64'hFFFF_FFFF_FFFF_FFEB);
      tick();
      mid();
      check("cont_pulse", {62'd0, resp_valid}, 64'd0);
      check("cont_grant1", {62'd0, req_ready}, 64'h2);
      tick();
      req_valid = 2'b11;
      set_ops(0, 32'd123, 32'd0);
      set_ops(1, 32'h8000_0000, 32'h8000_0000);
      wait_resp("mul_-6x4", 5, 2'b10, 64'hFFFF_FFFF_FFFF_FFE8);
      tick();
      mid();
      check("alt_grant0", {62'd0, req_ready}, 64'h1);
      tick();
      wait_resp("mul_op2_zero", 3, 2'b01, 64'd0);
      tick();
      mid();
      check("alt_grant1", {62'd0, req_ready}, 64'h2);
      tick();
      req_valid = 2'b00;
      wait_resp("mul_min_sq", 19, 2'b10, 64'h4000_0000_0000_0000);
      tick();
      resp_ready = 2'b00;
      mid();
      check("idle_after_alt", {63'd0, busy}, 64'd0);

      // flush in IDLE suppresses the grant, then flush mid-operation
      tick();
      flush = 1'b1; req_valid = 2'b01;
      set_ops(0, 32'h0001_2345, 32'h8000_0000);
      mid();
      check("flush_idle_nogrant", {62'd0, req_ready}, 64'd0);
      tick();
      flush = 1'b0;
      mid();
      check("flush_op_grant", {62'd0, req_ready}, 64'h1);
      tick();
      req_valid = 2'b00;
      tick(); tick(); tick();
      tick();
      flush = 1'b1;
      mid();
      check("flush_t5_busy", {63'd0, busy}, 64'd1);
      check("flush_t5_noresp", {62'd0, resp_valid}, 64'd0);
      tick();
      flush = 1'b0;
      mid();
      check("flush_t6_idle", {63'd0, busy}, 64'd0);
      tick(); tick(); tick();
      mid();
      check("flush_no_resp", {62'd0, resp_valid}, 64'd0);
      tick();
      req_valid = 2'b11;
      set_ops(0, 32'd5, 32'd5);
      set_ops(1, 32'd3, 32'd3);
      mid();
      check("flush_prio_kept", {62'd0, req_ready}, 64'h1);
      tick();
      req_valid = 2'b10;
      wait_resp("mul_5x5", 5, 2'b01, 64'd25);
      resp_ready = 2'b01;
      tick();
      resp_ready = 2'b00;
      mid();
      check("pending1_grant", {62'd0, req_ready}, 64'h2);
      tick();
      req_valid = 2'b00;
      wait_resp("mul_3x3", 4, 2'b10, 64'd9);
      resp_ready = 2'b10;
      tick();

      // backpressure: only the non-owner ready is high for 10 RESP cycles
      resp_ready = 2'b01; req_valid = 2'b10;
      set_ops(1, 32'h7FFF_FFFF, 32'd2);
      mid();
      check("bp_grant", {62'd0, req_ready}, 64'h2);
      tick();
      req_valid = 2'b00;
      wait_resp("mul_bp", 4, 2'b10, 64'h0000_0000_FFFF_FFFE);
      req_valid = 2'b01;
      set_ops(0, 32'd100, 32'hFFFF_FFFF);
      for (int i = 0; i < 10; i++) begin
         tick();
         mid();
         check("bp_hold_valid", {62'd0, resp_valid}, 64'h2);
         check("bp_hold_prod", resp_product, 64'h0000_0000_FFFF_FFFE);
         check("bp_no_grant", {62'd0, req_ready}, 64'd0);
      end
      resp_ready = 2'b10;
      tick();
      resp_ready = 2'b00;
      mid();
      check("bp_released", {62'd0, resp_valid}, 64'd0);
      check("bp_next_grant", {62'd0, req_ready}, 64'h1);
      tick();
      req_valid = 2'b00;
      wait_resp("mul_100x-1", 4, 2'b01, 64'hFFFF_FFFF_FFFF_FF9C);
      resp_ready = 2'b01;
      tick();
      resp_ready = 2'b00;

      // reset mid-BUSY; priority would otherwise favour port1
      req_valid = 2'b10;
      set_ops(1, 32'd1, 32'h8000_0000);
      mid();
      check("rstmid_grant", {62'd0, req_ready}, 64'h2);
      tick();
      req_valid = 2'b00;
      tick(); tick();
      rst = 1'b1; req_valid = 2'b11;
      set_ops(0, -32'sd9, -32'sd9);
      mid();
      check("rstmid_no_ready", {62'd0, req_ready}, 64'd0);
      tick();
      mid();
      check("rstmid_req_ready", {62'd0, req_ready}, 64'd0);
      check("rstmid_resp_valid", {62'd0, resp_valid}, 64'd0);
      check("rstmid_busy", {63'd0, busy}, 64'd0);
      check("rstmid_product", resp_product, 64'd0);
      tick();
      rst = 1'b0;
      mid();
      check("rstmid_prio_init", {62'd0, req_ready}, 64'h1);
      tick();
      req_valid = 2'b00;
      wait_resp("mul_-9x-9", 5, 2'b01, 64'd81);
      resp_ready = 2'b01;
      tick();
      resp_ready = 2'b00;
      mid();
      check("final_idle", {63'd0, busy}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
